// File: rtl/p874x_rom_loader_arb.sv
// Program-memory owner for the P874x core: arbitrates the SRAM between host load/readback
// (while the core is held in reset) and the core fetch path (while it runs).
module p874x_rom_loader_arb #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [11:0]       load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              load_done,
    output logic [7:0]        checksum,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [7:0]        rd_data,
    input  logic              run_start,
    input  logic              run_stop,
    output logic              cmd_err,
    output logic              running,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_rom_addr,
    output logic [7:0]        cpu_rom_val,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we
);

    localparam int unsigned LEN_W = 12;

    typedef enum logic [1:0] {ST_HOLD, ST_LOAD, ST_READ, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        checksum_d, rd_data_d;
    logic              load_done_d, rd_valid_d, cmd_err_d;
    logic [LEN_W-1:0]  len_clamped;
    logic              any_cmd;

    assign len_clamped = (load_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : load_len;
    assign any_cmd     = load_start | rd_req | run_start | run_stop;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            rem_q     <= '0;
            rd_addr_q <= '0;
            checksum  <= '0;
            rd_data   <= '0;
            load_done <= 1'b0;
            rd_valid  <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            rd_addr_q <= rd_addr_d;
            checksum  <= checksum_d;
            rd_data   <= rd_data_d;
            load_done <= load_done_d;
            rd_valid  <= rd_valid_d;
            cmd_err   <= cmd_err_d;
        end
    end

    // Next-state, memory routing and command checking
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        rd_addr_d   = rd_addr_q;
        checksum_d  = checksum;
        rd_data_d   = rd_data;
        load_done_d = 1'b0;
        rd_valid_d  = 1'b0;
        cmd_err_d   = cmd_err;
        in_ready    = 1'b0;
        cpu_rst     = 1'b1;
        running     = 1'b0;
        cpu_rom_val = 8'h00;
        mem_addr    = cpu_rom_addr;
        mem_wdata   = 8'h00;
        mem_we      = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (run_stop) cmd_err_d = 1'b1;
                if (load_start) begin
                    if (rd_req || run_start) cmd_err_d = 1'b1;
                    checksum_d = 8'h00;
                    if (len_clamped == '0) begin
                        load_done_d = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        rem_d   = len_clamped;
                        state_d = ST_LOAD;
                    end
                end else if (rd_req) begin
                    if (run_start) cmd_err_d = 1'b1;
                    rd_addr_d = rd_addr;
                    state_d   = ST_READ;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end

            ST_LOAD: begin
                in_ready  = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = in_data;
                mem_we    = in_valid;
                if (any_cmd) cmd_err_d = 1'b1;
                if (in_valid) begin
                    cnt_d      = cnt_q + ADDR_W'(1);
                    rem_d      = rem_q - LEN_W'(1);
                    checksum_d = checksum + in_data;
                    if (rem_q == LEN_W'(1)) begin
                        load_done_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end
            end

            ST_READ: begin
                mem_addr   = rd_addr_q;
                rd_data_d  = mem_rdata;
                rd_valid_d = 1'b1;
                state_d    = ST_HOLD;
                if (any_cmd) cmd_err_d = 1'b1;
            end

            ST_RUN: begin
                cpu_rst     = 1'b0;
                running     = 1'b1;
                cpu_rom_val = mem_rdata;
                if (load_start || rd_req || run_start) cmd_err_d = 1'b1;
                if (run_stop) state_d = ST_HOLD;
            end

            default: state_d = ST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_p874x_rom_loader_arb.sv
// Bench for p874x_rom_loader_arb: command-table vectors, directed load/read/run sequences,
// and randomized operations checked against a shadow-memory reference model.
module tb_p874x_rom_loader_arb;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 2048;

    logic              clk = 1'b0;
    logic              rst, load_start, in_valid, rd_req, run_start, run_stop;
    logic [11:0]       load_len;
    logic [7:0]        in_data;
    logic              in_ready, load_done, rd_valid, cmd_err, running, cpu_rst, mem_we;
    logic [7:0]        checksum, rd_data, cpu_rom_val, mem_rdata, mem_wdata;
    logic [ADDR_W-1:0] rd_addr, cpu_rom_addr, mem_addr;

    logic [7:0] sram    [DEPTH];
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] pay     [DEPTH];
    logic       exp_err;
    int         n_checks = 0;
    int         n_fail   = 0;

    p874x_rom_loader_arb #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .load_done(load_done),
        .checksum(checksum), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .run_start(run_start), .run_stop(run_stop), .cmd_err(cmd_err),
        .running(running), .cpu_rst(cpu_rst), .cpu_rom_addr(cpu_rom_addr),
        .cpu_rom_val(cpu_rom_val), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .mem_we(mem_we)
    );

    always #5 clk = ~clk;

    // Physical program SRAM: combinational read, write on rising edge
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_we) sram[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    // stall_mode: 0 none, 1 every other cycle, 2 random
    task automatic do_load(input int len_req, input int stall_mode, input int rst_after);
        int         len_c;
        int         sent;
        int         guard;
        int         writes;
        logic       v;
        logic [7:0] sum;
        len_c  = (len_req > int'(DEPTH)) ? int'(DEPTH) : len_req;
        sent   = 0;
        guard  = 0;
        writes = 0;
        sum    = 8'h00;
        load_start = 1'b1;
        load_len   = 12'(len_req);
        cyc();
        load_start = 1'b0;
        if (len_c == 0) begin
            #1;
            chk("zero_len_done", load_done, 1);
            chk("zero_len_sum", checksum, 0);
            chk("zero_len_ready", in_ready, 0);
            cyc();
            chk("zero_len_done_pulse", load_done, 0);
            return;
        end
        while (sent < len_c && guard < 20000) begin
            if (rst_after > 0 && sent == rst_after) break;
            case (stall_mode)
                0:       v = 1'b1;
                1:       v = guard[0] == 1'b0;
                default: v = $urandom_range(3) != 0;
            endcase
            in_valid = v;
            in_data  = pay[sent];
            #1;
            chk("load_in_ready", in_ready, 1);
            chk("load_mem_we", mem_we, v);
            chk("load_done_early", load_done, 0);
            if (v) begin
                chk("load_mem_addr", mem_addr, sent);
                chk("load_mem_wdata", mem_wdata, pay[sent]);
                writes++;
            end
            cyc();
            if (v) begin
                sum += pay[sent];
                exp_mem[sent] = pay[sent];
                sent++;
            end
            guard++;
        end
        in_valid = 1'b0;
        if (rst_after > 0) begin
            do_reset();
            #1;
            chk("rst_mid_sum", checksum, 0);
            chk("rst_mid_cpu_rst", cpu_rst, 1);
            chk("rst_mid_ready", in_ready, 0);
            chk("rst_mid_done", load_done, 0);
            return;
        end
        chk("load_writes", writes, len_c);
        #1;
        chk("load_done", load_done, 1);
        chk("load_checksum", checksum, sum);
        chk("load_ready_off", in_ready, 0);
        chk("load_we_off", mem_we, 0);
        chk("load_cpu_rst", cpu_rst, 1);
        cyc();
        chk("load_done_pulse", load_done, 0);
    endtask

    task automatic do_read(input int addr);
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(addr);
        cyc();
        rd_req = 1'b0;
        #1;
        chk("rd_valid_n1", rd_valid, 0);
        chk("rd_mem_addr", mem_addr, addr);
        chk("rd_cpu_rst", cpu_rst, 1);
        cyc();
        chk("rd_valid_n2", rd_valid, 1);
        chk("rd_data", rd_data, exp_mem[addr]);
        chk("rd_cpu_rst2", cpu_rst, 1);
        cyc();
        chk("rd_valid_pulse", rd_valid, 0);
    endtask

    task automatic do_run(input int nfetch, input logic stray);
        int a;
        run_start = 1'b1;
        cyc();
        run_start = 1'b0;
        #1;
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_running", running, 1);
        for (int i = 0; i < nfetch; i++) begin
            a = int'($urandom_range(DEPTH - 1));
            cpu_rom_addr = ADDR_W'(a);
            rd_req = stray && (i == 0);
            if (rd_req) exp_err = 1'b1;
            #1;
            chk("fetch_val", cpu_rom_val, exp_mem[a]);
            chk("fetch_no_we", mem_we, 0);
            cyc();
            rd_req = 1'b0;
        end
        run_stop = 1'b1;
        cyc();
        run_stop = 1'b0;
        #1;
        chk("stop_cpu_rst", cpu_rst, 1);
        chk("stop_running", running, 0);
        chk("hold_rom_val", cpu_rom_val, 0);
        chk("run_rd_valid", rd_valid, 0);
        chk("run_cmd_err", cmd_err, exp_err);
    endtask

    typedef struct {
        string name;
        logic  r, ls, rq, rs, sp;
        logic  e_run, e_crst, e_err, e_rdy;
    } vec_t;

    vec_t vecs[16];

    initial begin
        rst = 1'b1; load_start = 0; load_len = '0; in_valid = 0; in_data = '0;
        rd_req = 0; rd_addr = '0; run_start = 0; run_stop = 0; cpu_rom_addr = '0;
        exp_err = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sram[i]    = 8'h00;
            exp_mem[i] = 8'h00;
        end
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_running", running, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_cmd_err", cmd_err, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);

        // Command acceptance / cmd_err table; expectations apply after the edge
        vecs[0]  = '{"v_rst",          1,0,0,0,0, 0,1,0,0};
        vecs[1]  = '{"v_run",          0,0,0,1,0, 1,0,0,0};
        vecs[2]  = '{"v_rd_in_run",    0,0,1,0,0, 1,0,1,0};
        vecs[3]  = '{"v_stop",         0,0,0,0,1, 0,1,1,0};
        vecs[4]  = '{"v_rst2",         1,0,0,0,0, 0,1,0,0};
        vecs[5]  = '{"v_rd_and_run",   0,0,1,1,0, 0,1,1,0};
        vecs[6]  = '{"v_read_idle",    0,0,0,0,0, 0,1,1,0};
        vecs[7]  = '{"v_rst3",         1,0,0,0,0, 0,1,0,0};
        vecs[8]  = '{"v_stop_in_hold", 0,0,0,0,1, 0,1,1,0};
        vecs[9]  = '{"v_rst4",         1,0,0,0,0, 0,1,0,0};
        vecs[10] = '{"v_run2",         0,0,0,1,0, 1,0,0,0};
        vecs[11] = '{"v_stop_and_ld",  0,1,0,0,1, 0,1,1,0};
        vecs[12] = '{"v_no_load",      0,0,0,0,0, 0,1,1,0};
        vecs[13] = '{"v_rst5",         1,0,0,0,0, 0,1,0,0};
        vecs[14] = '{"v_ld_and_run",   0,1,0,1,0, 0,1,1,1};
        vecs[15] = '{"v_rst_in_load",  1,0,0,0,0, 0,1,0,0};
        load_len = 12'd4;
        foreach (vecs[i]) begin
            rst = vecs[i].r; load_start = vecs[i].ls; rd_req = vecs[i].rq;
            run_start = vecs[i].rs; run_stop = vecs[i].sp;
            cyc();
            rst = 0; load_start = 0; rd_req = 0; run_start = 0; run_stop = 0;
            #1;
            chk({vecs[i].name, "_running"}, running, vecs[i].e_run);
            chk({vecs[i].name, "_cpu_rst"}, cpu_rst, vecs[i].e_crst);
            chk({vecs[i].name, "_cmd_err"}, cmd_err, vecs[i].e_err);
            chk({vecs[i].name, "_in_ready"}, in_ready, vecs[i].e_rdy);
        end
        do_reset();

        // Four-byte load, no stalls: checksum 0x50
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'hF0;
        do_load(4, 0, 0);
        chk("t1_checksum", checksum, 8'h50);
        do_read(2);
        chk("t3_rd_data", rd_data, 8'h30);

        // Run, fetch address 1, illegal readback while running
        run_start = 1'b1;
        cyc();
        run_start = 1'b0;
        #1;
        chk("t4_cpu_rst", cpu_rst, 0);
        cpu_rom_addr = ADDR_W'(1);
        #1;
        chk("t4_rom_val", cpu_rom_val, 8'h20);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        #1;
        chk("t4_cmd_err", cmd_err, 1);
        chk("t4_rd_valid1", rd_valid, 0);
        cyc();
        chk("t4_rd_valid2", rd_valid, 0);
        chk("t4_still_run", running, 1);
        run_stop = 1'b1;
        cyc();
        run_stop = 1'b0;
        do_reset();

        // Three-byte load with in_valid toggling, then zero-length load
        pay[0] = 8'hA1; pay[1] = 8'h5B; pay[2] = 8'hC7;
        do_load(3, 1, 0);
        do_read(2);
        do_read(3);
        do_load(0, 0, 0);

        // Oversize length clamps to DEPTH; then reset in the middle of a load
        for (int i = 0; i < int'(DEPTH); i++) pay[i] = 8'($urandom);
        do_load(4095, 0, 0);
        do_read(0);
        do_read(int'(DEPTH) - 1);
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        do_load(10, 0, 5);
        do_read(4);
        do_read(5);

        // Randomized operations against the shadow-memory model
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(3))
                0: begin
                    for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
                    do_load(int'($urandom_range(64)), 2, 0);
                end
                1: do_read(int'($urandom_range(DEPTH - 1)));
                2: do_run(int'($urandom_range(1, 6)), $urandom_range(3) == 0);
                default: begin
                    do_reset();
                    #1;
                    chk("rand_rst_err", cmd_err, 0);
                end
            endcase
            chk("rand_cmd_err", cmd_err, exp_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
